fwrisc_rf_rdport_arbiter: RTL

Shares the register file's two read ports (ra/rb, 6-bit address, registered one-cycle read data) between two requesters: requester 0 is the decode stage, requester 1 is a secondary client such as a debug or CSR-access unit. The arbiter issues at most one two-operand read per cycle and returns both operands to the winning requester with a valid strobe. It sits between the requesters and the register file.

---
 rtl/fwrisc_rf_rdport_arbiter.sv | 110 +++++++++++
 1 files changed

// File: rtl/fwrisc_rf_rdport_arbiter.sv
// rtl/fwrisc_rf_rdport_arbiter.sv - two-requester arbiter for the register file's paired read ports
module fwrisc_rf_rdport_arbiter #(
   parameter int PRIORITY_MODE = 0,
   parameter int MAX_BURST     = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req0,
   input  logic [5:0]  raddr_a0,
   input  logic [5:0]  raddr_b0,
   input  logic        req1,
   input  logic [5:0]  raddr_a1,
   input  logic [5:0]  raddr_b1,
   output logic        gnt0,
   output logic        gnt1,
   output logic        rvalid0,
   output logic        rvalid1,
   output logic [31:0] rdata_a0,
   output logic [31:0] rdata_b0,
   output logic [31:0] rdata_a1,
   output logic [31:0] rdata_b1,
   output logic [5:0]  ra_raddr,
   output logic [5:0]  rb_raddr,
   input  logic [31:0] ra_rdata,
   input  logic [31:0] rb_rdata
);

   typedef enum logic {IDLE, BUSY} state_t;

   localparam logic [3:0] BURST_LIMIT = 4'(MAX_BURST);

   state_t      state, state_nxt;
   logic        owner;
   logic        last, last_nxt;
   logic [3:0]  count, count_nxt;
   logic [5:0]  addr_a_q, addr_b_q;
   logic [31:0] hold_a0, hold_b0, hold_a1, hold_b1;
   logic        tie, pick1, issue;

   always_comb begin
      gnt0      = 1'b0;
      gnt1      = 1'b0;
      state_nxt = IDLE;
      last_nxt  = last;
      count_nxt = 4'd0;
      tie       = req0 & req1;
      pick1     = ~req0;
      // `last` and `count` describe the current contested burst; lone grants leave `last` alone
      if (PRIORITY_MODE == 0 && tie) begin
         if (count != 4'd0 && count < BURST_LIMIT)
            pick1 = last;
         else
            pick1 = ~last;
      end
      if (rst_n) begin
         gnt0 = (req0 | req1) & ~pick1;
         gnt1 = (req0 | req1) & pick1;
      end
      issue = gnt0 | gnt1;
      if (issue)
         state_nxt = BUSY;
      if (issue && tie) begin
         last_nxt = pick1;
         if (pick1 == last && count != 4'd0)
            count_nxt = (count == 4'd15) ? count : count + 4'd1;
         else
            count_nxt = 4'd1;
      end
      ra_raddr = gnt1 ? raddr_a1 : (gnt0 ? raddr_a0 : addr_a_q);
      rb_raddr = gnt1 ? raddr_b1 : (gnt0 ? raddr_b0 : addr_b_q);
      rvalid0  = (state == BUSY) && !owner;
      rvalid1  = (state == BUSY) && owner;
      rdata_a0 = rvalid0 ? ra_rdata : hold_a0;
      rdata_b0 = rvalid0 ? rb_rdata : hold_b0;
      rdata_a1 = rvalid1 ? ra_rdata : hold_a1;
      rdata_b1 = rvalid1 ? rb_rdata : hold_b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         owner    <= 1'b0;
         last     <= 1'b1;
         count    <= 4'd0;
         addr_a_q <= 6'd0;
         addr_b_q <= 6'd0;
         hold_a0  <= 32'd0;
         hold_b0  <= 32'd0;
         hold_a1  <= 32'd0;
         hold_b1  <= 32'd0;
      end else begin
         state    <= state_nxt;
         last     <= last_nxt;
         count    <= count_nxt;
         addr_a_q <= ra_raddr;
         addr_b_q <= rb_raddr;
         if (issue)
            owner <= gnt1;
         if (rvalid0) begin
            hold_a0 <= ra_rdata;
            hold_b0 <= rb_rdata;
         end
         if (rvalid1) begin
            hold_a1 <= ra_rdata;
            hold_b1 <= rb_rdata;
         end
      end
   end

endmodule
